// File: rtl/rv32i_bus_unit.sv
// Wishbone classic master that serialises the core's data access and instruction fetch.
// Optional bus-cycle watchdog enabled by defining RV32I_BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module rv32i_bus_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           current_pc,
    output logic [31:0]           inst,
    input  logic [31:0]           mem_addr_mem,
    input  logic [31:0]           mem_wdata_mem,
    input  logic                  mem_write_mem,
    input  logic                  mem_read_mem,
    input  logic [2:0]            mem_op_mem,
    output logic [31:0]           mem_rdata_mem,
    output logic                  stall_pipl,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [31:0]           wb_dat_o,
    output logic [3:0]            wb_sel_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    output logic                  bus_err,
    output logic                  misaligned
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;
    state_t state, next_state;

    logic                  req, misalign_req, term, term_err, timeout;
    logic                  err_flag, mis_flag;
    logic                  cyc_n, we_n, bus_err_n;
    logic [3:0]            sel_n, sel_data;
    logic [ADDR_WIDTH-1:0] adr_n;
    logic [31:0]           dat_n, dat_data, shifted, load_ext;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^current_pc[1:0];

`ifdef RV32I_BUS_TIMEOUT_EN
    logic [31:0] wd_cnt;

    // Fires in the TIMEOUT_CYCLES-th strobe cycle that saw no termination.
    assign timeout = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wd_cnt <= '0;
        else if (state != next_state)
            wd_cnt <= '0;
        else if (wb_stb_o)
            wd_cnt <= wd_cnt + 32'd1;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign req          = mem_read_mem | mem_write_mem;
    assign misalign_req = req & ((mem_op_mem[1:0] == 2'b01 && mem_addr_mem[0]) ||
                                 (mem_op_mem[1] && mem_addr_mem[1:0] != 2'b00));

    always_comb begin
        sel_data = 4'hF;
        dat_data = mem_wdata_mem;
        shifted  = wb_dat_i >> {mem_addr_mem[1:0], 3'b000};
        load_ext = wb_dat_i;
        case (mem_op_mem[1:0])
            2'b00: begin
                sel_data = 4'b0001 << mem_addr_mem[1:0];
                dat_data = {4{mem_wdata_mem[7:0]}};
                load_ext = {{24{~mem_op_mem[2] & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                sel_data = 4'b0011 << {mem_addr_mem[1], 1'b0};
                dat_data = {2{mem_wdata_mem[15:0]}};
                load_ext = {{16{~mem_op_mem[2] & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        term       = 1'b0;
        term_err   = 1'b0;
        case (state)
            IDLE: next_state = (req && !misalign_req) ? DATA : FETCH;
            DATA, FETCH: begin
                term     = wb_ack_i | wb_err_i | timeout;
                term_err = wb_err_i | timeout;
                if (term)
                    next_state = (state == DATA) ? FETCH : DONE;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase

        // Bus outputs are registered, so they are decoded from the state being entered.
        cyc_n = (next_state == DATA) || (next_state == FETCH);
        we_n  = 1'b0;
        sel_n = '0;
        adr_n = '0;
        dat_n = '0;
        if (next_state == DATA) begin
            we_n  = mem_write_mem;
            sel_n = sel_data;
            adr_n = mem_addr_mem[ADDR_WIDTH-1:0];
            dat_n = dat_data;
        end else if (next_state == FETCH) begin
            sel_n = 4'hF;
            adr_n = {current_pc[ADDR_WIDTH-1:2], 2'b00};
        end
        bus_err_n = (next_state == DONE) && (err_flag || (state == FETCH && term_err));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_sel_o      <= '0;
            wb_adr_o      <= '0;
            wb_dat_o      <= '0;
            stall_pipl    <= 1'b1;
            bus_err       <= 1'b0;
            misaligned    <= 1'b0;
            err_flag      <= 1'b0;
            mis_flag      <= 1'b0;
            inst          <= NOP;
            mem_rdata_mem <= '0;
        end else begin
            state      <= next_state;
            wb_cyc_o   <= cyc_n;
            wb_stb_o   <= cyc_n;
            wb_we_o    <= we_n;
            wb_sel_o   <= sel_n;
            wb_adr_o   <= adr_n;
            wb_dat_o   <= dat_n;
            stall_pipl <= (next_state != DONE);
            bus_err    <= bus_err_n;
            misaligned <= (next_state == DONE) && mis_flag;

            if (state == IDLE) begin
                err_flag <= 1'b0;
                mis_flag <= misalign_req;
                if (misalign_req && mem_read_mem)
                    mem_rdata_mem <= '0;
            end
            if (state == DATA && term) begin
                if (term_err)
                    err_flag <= 1'b1;
                if (mem_read_mem)
                    mem_rdata_mem <= term_err ? '0 : load_ext;
            end
            if (state == FETCH && term)
                inst <= term_err ? NOP : wb_dat_i;
        end
    end
endmodule

// File: tb/tb_rv32i_bus_unit.sv
// Scoreboard bench for rv32i_bus_unit: a slave model checks each bus transfer,
// a monitor checks the per-epoch results whenever the unit reaches DONE.
`timescale 1ns/1ps
module tb_rv32i_bus_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] current_pc, inst, mem_addr_mem, mem_wdata_mem, mem_rdata_mem;
    logic        mem_write_mem, mem_read_mem, stall_pipl;
    logic [2:0]  mem_op_mem;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i, bus_err, misaligned;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;

    rv32i_bus_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .current_pc(current_pc), .inst(inst),
        .mem_addr_mem(mem_addr_mem), .mem_wdata_mem(mem_wdata_mem),
        .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem),
        .mem_op_mem(mem_op_mem), .mem_rdata_mem(mem_rdata_mem), .stall_pipl(stall_pipl),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .bus_err(bus_err), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr, dat, rdata;
        logic [3:0]  sel;
        logic        we, err, ackerr, hang;
        int          waits;
    } xfer_t;

    typedef struct {
        logic [31:0] inst, rdata;
        logic        berr, mis;
    } out_t;

    xfer_t xq[$];
    out_t  oq[$];
    int    passed = 0;
    int    total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic xfer(input logic [31:0] adr, input logic [3:0] sel, input logic we,
                        input logic [31:0] dat, input logic [31:0] rdata, input int waits,
                        input logic err, input logic ackerr, input logic hang);
        xfer_t x;
        x.adr = adr; x.sel = sel; x.we = we; x.dat = dat; x.rdata = rdata;
        x.waits = waits; x.err = err; x.ackerr = ackerr; x.hang = hang;
        xq.push_back(x);
    endtask

    task automatic outexp(input logic [31:0] i, input logic [31:0] r, input logic b, input logic m);
        out_t o;
        o.inst = i; o.rdata = r; o.berr = b; o.mis = m;
        oq.push_back(o);
    endtask

    // Slave model: checks the request of each new transfer, then answers after its wait states.
    xfer_t cur;
    logic  in_xfer = 1'b0;
    int    wcnt = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            wb_ack_i = 1'b0; wb_err_i = 1'b0; in_xfer = 1'b0;
        end else if (wb_cyc_o && wb_stb_o) begin
            if (!in_xfer) begin
                if (xq.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_transfer actual adr=%h required none", wb_adr_o);
                    cur = '{default: '0};
                end else begin
                    cur = xq.pop_front();
                    chk("xfer_adr", wb_adr_o, cur.adr);
                    chk("xfer_sel", {28'd0, wb_sel_o}, {28'd0, cur.sel});
                    chk("xfer_we", {31'd0, wb_we_o}, {31'd0, cur.we});
                    if (cur.we) chk("xfer_dat", wb_dat_o, cur.dat);
                end
                in_xfer = 1'b1;
                wcnt = cur.waits;
            end
            if (cur.hang) begin
                wb_ack_i = 1'b0; wb_err_i = 1'b0;
            end else if (wcnt == 0) begin
                wb_ack_i = !cur.err || cur.ackerr;
                wb_err_i = cur.err;
                wb_dat_i = cur.rdata;
                in_xfer  = 1'b0;
            end else begin
                wcnt--;
                wb_ack_i = 1'b0; wb_err_i = 1'b0;
            end
        end else begin
            wb_ack_i = 1'b0; wb_err_i = 1'b0; in_xfer = 1'b0;
        end
    end

    // Monitor: every DONE cycle pops one expected epoch result.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("stall_low_one_cycle", {31'd0, stall_pipl}, 32'd1);
            prev_done = !stall_pipl;
            if (!stall_pipl) begin
                if (oq.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done actual=DONE required=no_epoch_pending");
                end else begin
                    out_t e;
                    e = oq.pop_front();
                    chk("inst", inst, e.inst);
                    chk("rdata", mem_rdata_mem, e.rdata);
                    chk("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
                    chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                end
            end
        end
    end

    task automatic drive(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rd, input logic wr, input logic [2:0] op);
        current_pc = pc; mem_addr_mem = addr; mem_wdata_mem = wdata;
        mem_read_mem = rd; mem_write_mem = wr; mem_op_mem = op;
    endtask

    // Counts cycles from IDLE up to and including DONE; ends just after that DONE sample.
    task automatic count(input int exp_len, input int exp_cyc);
        int n = 0;
        int c = 0;
        logic done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            n++;
            if (wb_cyc_o) c++;
            if (!stall_pipl) done = 1'b1;
        end
        if (!done) begin
            total++;
            $display("FAIL epoch_timeout actual=no_DONE required=DONE_within_100");
        end
        chk("epoch_len", n, exp_len);
        chk("epoch_cyc_cycles", c, exp_cyc);
        #1;
    endtask

    task automatic epoch(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rd, input logic wr, input logic [2:0] op,
                         input int exp_len, input int exp_cyc);
        drive(pc, addr, wdata, rd, wr, op);
        count(exp_len, exp_cyc);
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
        chk({tag, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
        chk({tag, "_we"}, {31'd0, wb_we_o}, 32'd0);
        chk({tag, "_adr"}, wb_adr_o, 32'd0);
        chk({tag, "_dat"}, wb_dat_o, 32'd0);
        chk({tag, "_sel"}, {28'd0, wb_sel_o}, 32'd0);
        chk({tag, "_inst"}, inst, NOP);
        chk({tag, "_rdata"}, mem_rdata_mem, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_pipl}, 32'd1);
        chk({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
        chk({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n = 1'b0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
        drive(32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
        xfer(32'h100, 4'hF, 1'b0, 32'h0, 32'h0050_0093, 0, 1'b0, 1'b0, 1'b0);
        outexp(32'h0050_0093, 32'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset_values("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        count(3, 1);

        // LB 0x203: top byte 0x80 sign-extended
        xfer(32'h203, 4'b1000, 1'b0, 32'h0, 32'h80FF_1234, 0, 1'b0, 1'b0, 1'b0);
        xfer(32'h104, 4'hF, 1'b0, 32'h0, 32'h0010_0113, 0, 1'b0, 1'b0, 1'b0);
        outexp(32'h0010_0113, 32'hFFFF_FF80, 1'b0, 1'b0);
        epoch(32'h104, 32'h203, 32'h0, 1'b1, 1'b0, 3'b000, 4, 2);

        // SH 0x202: slave read data chosen so the held load value is unchanged either way
        xfer(32'h202, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'hFF80_0000, 0, 1'b0, 1'b0, 1'b0);
        xfer(32'h108, 4'hF, 1'b0, 32'h0, 32'h0020_8193, 0, 1'b0, 1'b0, 1'b0);
        outexp(32'h0020_8193, 32'hFFFF_FF80, 1'b0, 1'b0);
        epoch(32'h108, 32'h202, 32'h0000_ABCD, 1'b0, 1'b1, 3'b001, 4, 2);

        // LHU 0x206 with two wait states
        xfer(32'h206, 4'b1100, 1'b0, 32'h0, 32'h8001_7FFF, 2, 1'b0, 1'b0, 1'b0);
        xfer(32'h10C, 4'hF, 1'b0, 32'h0, 32'h0030_8213, 0, 1'b0, 1'b0, 1'b0);
        outexp(32'h0030_8213, 32'h0000_8001, 1'b0, 1'b0);
        epoch(32'h10C, 32'h206, 32'h0, 1'b1, 1'b0, 3'b101, 6, 4);

        // LBU 0x201
        xfer(32'h201, 4'b0010, 1'b0, 32'h0, 32'h0000_C300, 0, 1'b0, 1'b0, 1'b0);
        xfer(32'h110, 4'hF, 1'b0, 32'h0, 32'h0041_0293, 0, 1'b0, 1'b0, 1'b0);
        outexp(32'h0041_0293, 32'h0000_00C3, 1'b0, 1'b0);
        epoch(32'h110, 32'h201, 32'h0, 1'b1, 1'b0, 3'b100, 4, 2);

        // LH 0x200
        xfer(32'h200, 4'b0011, 1'b0, 32'h0, 32'h1234_8765, 0, 1'b0, 1'b0, 1'b0);
        xfer(32'h114, 4'hF, 1'b0, 32'h0, 32'h0051_0313, 0, 1'b0, 1'b0, 1'b0);
        outexp(32'h0051_0313, 32'hFFFF_8765, 1'b0, 1'b0);
        epoch(32'h114, 32'h200, 32'h0, 1'b1, 1'b0, 3'b001, 4, 2);

        // LW 0x300, one wait state on each transfer
        xfer(32'h300, 4'hF, 1'b0, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 1'b0);
        xfer(32'h118, 4'hF, 1'b0, 32'h0, 32'h0061_0393, 1, 1'b0, 1'b0, 1'b0);
        outexp(32'h0061_0393, 32'hDEAD_BEEF, 1'b0, 1'b0);
        epoch(32'h118, 32'h300, 32'h0, 1'b1, 1'b0, 3'b010, 6, 4);

        // misaligned LW 0x201: fetch only
        xfer(32'h11C, 4'hF, 1'b0, 32'h0, 32'h0071_0413, 0, 1'b0, 1'b0, 1'b0);
        outexp(32'h0071_0413, 32'h0, 1'b0, 1'b1);
        epoch(32'h11C, 32'h201, 32'h0, 1'b1, 1'b0, 3'b010, 3, 1);

        // SB 0x101
        xfer(32'h101, 4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h0, 0, 1'b0, 1'b0, 1'b0);
        xfer(32'h120, 4'hF, 1'b0, 32'h0, 32'h0081_0493, 0, 1'b0, 1'b0, 1'b0);
        outexp(32'h0081_0493, 32'h0, 1'b0, 1'b0);
        epoch(32'h120, 32'h101, 32'h0000_00A5, 1'b0, 1'b1, 3'b000, 4, 2);

        // fetch with ack and err together
        xfer(32'h124, 4'hF, 1'b0, 32'h0, 32'h1111_1111, 0, 1'b1, 1'b1, 1'b0);
        outexp(NOP, 32'h0, 1'b1, 1'b0);
        epoch(32'h124, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010, 3, 1);

        // load terminated by err
        xfer(32'h400, 4'hF, 1'b0, 32'h0, 32'h5555_5555, 0, 1'b1, 1'b0, 1'b0);
        xfer(32'h128, 4'hF, 1'b0, 32'h0, 32'h00C0_0613, 0, 1'b0, 1'b0, 1'b0);
        outexp(32'h00C0_0613, 32'h0, 1'b1, 1'b0);
        epoch(32'h128, 32'h400, 32'h0, 1'b1, 1'b0, 3'b010, 4, 2);

        // hung slave
        xfer(32'h12C, 4'hF, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1);
`ifdef RV32I_BUS_TIMEOUT_EN
        outexp(NOP, 32'h0, 1'b1, 1'b0);
        epoch(32'h12C, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010, 6, 4);
        xfer(32'h130, 4'hF, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1);
        drive(32'h130, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
        repeat (2) @(negedge clk);
`else
        drive(32'h12C, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
        repeat (20) @(negedge clk);
        chk("hang_stall", {31'd0, stall_pipl}, 32'd1);
        chk("hang_cyc", {31'd0, wb_cyc_o}, 32'd1);
`endif
        #2 reset_n = 1'b0;
        #1 reset_values("midreset");
        xq.delete();
        chk("no_pending_epochs", oq.size(), 0);

        drive(32'h200, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
        xfer(32'h200, 4'hF, 1'b0, 32'h0, 32'h0000_0073, 0, 1'b0, 1'b0, 1'b0);
        outexp(32'h0000_0073, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        count(3, 1);
        chk("xfers_consumed", xq.size(), 0);
        chk("epochs_consumed", oq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rv32i_bus_unit.md
# rv32i_bus_unit

Parametrised memory-bus unit between the rv32i core and the SoC Wishbone fabric. It serialises the core's instruction fetch and data access onto one Wishbone classic master port and performs byte-lane steering, load extension and misalignment detection. It generates `stall_pipl` to freeze the pipeline until both requests of the current core cycle have completed. An optional watchdog terminates hung bus cycles.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: Wishbone address width; core addresses are truncated to the low `ADDR_WIDTH` bits.
- `TIMEOUT_CYCLES`, 255: bus-cycle watchdog limit, ≥1. Used only with `RV32I_BUS_TIMEOUT_EN`.

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `current_pc`  in  32  fetch address.
- `inst`  out  32  fetched instruction, held between fetches.
- `mem_addr_mem`  in  32  data address.
- `mem_wdata_mem`  in  32  store data, right-aligned.
- `mem_write_mem`  in  1  store request.
- `mem_read_mem`  in  1  load request.
- `mem_op_mem`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `mem_rdata_mem`  out  32  extended load data, held.
- `stall_pipl`  out  1  pipeline freeze.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone controls.
- `wb_adr_o`  out  ADDR_WIDTH  byte address.
- `wb_dat_o`  out  32  write data.
- `wb_sel_o`  out  4  byte lanes.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`, `wb_err_i`  in  1  cycle termination.
- `bus_err`  out  1  one-cycle pulse in DONE if any transfer of the epoch ended in error.
- `misaligned`  out  1  one-cycle pulse in DONE if the data access was misaligned.

## Operation
- FSM states: IDLE, DATA, FETCH, DONE. The reset state is IDLE.
- IDLE:
  - Samples the request.
  - If `mem_read_mem|mem_write_mem` and the access is aligned, go to DATA.
  - If the access is misaligned (H with addr[0]=1, W with addr[1:0]≠0), perform no bus cycle, set the misaligned flag, return load data 0, and go to FETCH.
  - Otherwise go to FETCH.
- DATA: `cyc=stb=1`, `we=mem_write_mem`.
  - Lanes: B uses `sel=1<<addr[1:0]` and `dat_o={4{wdata[7:0]}}`. H uses `sel=4'b0011<<(2*addr[1])` and `dat_o={2{wdata[15:0]}}`. W uses `sel=4'hF`.
  - On ack or err, latch load data, then go to FETCH.
  - Load data is extracted from the selected lane(s); B/H are sign-extended and BU/HU zero-extended.
- FETCH: `cyc=stb=1`, `we=0`, `sel=4'hF`, `adr={current_pc[ADDR_WIDTH-1:2],2'b00}`.
  - On ack or err, latch `inst`, then go to DONE.
- DONE: `cyc=stb=0`, `stall_pipl=0`, error/misaligned pulses asserted; go to IDLE.
- `stall_pipl=1` in every state except DONE.
- Error termination: `wb_err_i` terminates the transfer like ack. A load returns 0; a fetch returns NOP 32'h00000013.
- If `wb_ack_i` and `wb_err_i` are asserted together, err wins.
- Ack/err seen in IDLE or DONE is ignored.
- `wb_cyc_o` stays high from DATA through FETCH (back-to-back classic transfers).
- Reset values: all Wishbone outputs 0, `inst`=32'h00000013, `mem_rdata_mem`=0, `stall_pipl`=1, `bus_err`=0, `misaligned`=0.
- Reset mid-transfer drops `cyc`/`stb` asynchronously; the late ack is discarded.

## Timing
- Wishbone outputs and `stall_pipl` are registered. `wb_dat_i` is sampled on the ack/err edge.
- Fetch only, zero-wait slave (ack in the first stb cycle): IDLE, FETCH, DONE = 3 cycles per instruction.
- With an aligned data access: 4 cycles. Each slave wait state adds one cycle.
- `inst` and `mem_rdata_mem` update on the ack edge and are stable from DONE until the next ack.
- Request inputs must be stable while `stall_pipl=1`.

## Configuration
- `RV32I_BUS_TIMEOUT_EN` defined:
  - A counter clears on entry to DATA/FETCH and increments every stb cycle without ack/err.
  - Reaching `TIMEOUT_CYCLES` terminates the transfer as an error (NOP/0 returned, `bus_err` pulsed) and advances the FSM.
- Not defined: no counter; the unit waits indefinitely and `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset release, fetch pc=0x100, slave acks the first stb cycle with 0x00500093 -> `adr`=0x100, `sel`=F, `inst`=0x00500093, `stall_pipl` low exactly one cycle (DONE).
- LB addr=0x203, op=000, slave data 0x80FF1234 -> `sel`=1000, `mem_rdata_mem`=0xFFFFFF80; then the FETCH transfer follows with `cyc_o` continuously high.
- SH addr=0x202, wdata=0x0000ABCD -> `we`=1, `sel`=1100, `dat_o`=0xABCDABCD, two transfers, 4-cycle epoch.
- LW addr=0x201 -> no data bus cycle, `mem_rdata_mem`=0, `misaligned` pulse in DONE, fetch still performed.
- Fetch terminated with `ack` and `err` in the same cycle -> `inst`=0x00000013, `bus_err` pulse.
- With the macro and `TIMEOUT_CYCLES`=4, the slave never acks -> stb high 4 cycles, `bus_err` pulse, `inst`=NOP. Without the macro, `stall_pipl` stays high. Assert `reset_n` mid-stall -> `cyc_o` drops immediately.
